intra_ref_fetch: RTL and testbench

Reference-sample fetcher for the intra reconstruction path. On each start it reads the left-neighbour column and the top/top-right neighbour row for one intra block from the row, column and frame boundary SRAMs. It issues one SRAM read per cycle and streams the returned 4-pixel words to the predictor, in order and with an index. Unavailable neighbours are replaced by mid-grey padding.

---
 rtl/intra_ref_fetch_if.sv | 48 ++++
 rtl/intra_ref_fetch.sv | 185 ++++++++++++++++++
 tb/tb_intra_ref_fetch.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/intra_ref_fetch_if.sv
// rtl/intra_ref_fetch_if.sv - request, SRAM read and reference stream bundle for intra_ref_fetch
interface intra_ref_fetch_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int PIC_X_WIDTH = 8
);
    logic                       start_i;
    logic [1:0]                 size_i;
    logic [5:0]                 blk_x_i;
    logic [5:0]                 blk_y_i;
    logic [PIC_X_WIDTH-1:0]     lcu_x_i;
    logic                       avail_left_i;
    logic                       avail_top_i;
    logic                       avail_tr_i;

    logic                       rd_ena_row_o;
    logic [7:0]                 rd_adr_row_o;
    logic                       rd_ena_col_o;
    logic [7:0]                 rd_adr_col_o;
    logic                       rd_ena_fra_o;
    logic [PIC_X_WIDTH+3:0]     rd_adr_fra_o;
    logic [4*PIXEL_WIDTH-1:0]   rd_dat_row_i;
    logic [4*PIXEL_WIDTH-1:0]   rd_dat_col_i;
    logic [4*PIXEL_WIDTH-1:0]   rd_dat_fra_i;

    logic                       busy_o;
    logic                       ref_val_o;
    logic [4:0]                 ref_idx_o;
    logic [4*PIXEL_WIDTH-1:0]   ref_dat_o;
    logic                       done_o;

    modport master (
        output start_i, size_i, blk_x_i, blk_y_i, lcu_x_i,
               avail_left_i, avail_top_i, avail_tr_i,
               rd_dat_row_i, rd_dat_col_i, rd_dat_fra_i,
        input  rd_ena_row_o, rd_adr_row_o, rd_ena_col_o, rd_adr_col_o,
               rd_ena_fra_o, rd_adr_fra_o,
               busy_o, ref_val_o, ref_idx_o, ref_dat_o, done_o
    );

    modport slave (
        input  start_i, size_i, blk_x_i, blk_y_i, lcu_x_i,
               avail_left_i, avail_top_i, avail_tr_i,
               rd_dat_row_i, rd_dat_col_i, rd_dat_fra_i,
        output rd_ena_row_o, rd_adr_row_o, rd_ena_col_o, rd_adr_col_o,
               rd_ena_fra_o, rd_adr_fra_o,
               busy_o, ref_val_o, ref_idx_o, ref_dat_o, done_o
    );
endinterface

// File: rtl/intra_ref_fetch.sv
// rtl/intra_ref_fetch.sv - left/top/top-right intra reference fetcher with mid-grey padding
module intra_ref_fetch #(
    parameter int PIXEL_WIDTH = 8,
    parameter int PIC_X_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    intra_ref_fetch_if.slave    bus
);
    localparam int FW = PIC_X_WIDTH + 4;
    localparam int DW = 4 * PIXEL_WIDTH;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LEFT  = 2'd1;
    localparam logic [1:0] TOP   = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic [1:0] SRC_PAD = 2'd0;
    localparam logic [1:0] SRC_COL = 2'd1;
    localparam logic [1:0] SRC_ROW = 2'd2;
    localparam logic [1:0] SRC_FRA = 2'd3;

    localparam logic [PIXEL_WIDTH-1:0] PIX_MID  = {1'b1, {(PIXEL_WIDTH-1){1'b0}}};
    localparam logic [DW-1:0]          PAD_WORD = {4{PIX_MID}};

    logic [1:0]             state;
    logic [4:0]             cnt;
    logic [1:0]             size_q;
    logic [3:0]             bx_q;
    logic [3:0]             by_q;
    logic [PIC_X_WIDTH-1:0] lcu_q;
    logic                   al_q, at_q, atr_q;

    logic                   val_q;
    logic [4:0]             idx_q;
    logic [1:0]             tag_q;
    logic                   done_q;

    logic [4:0]             n_words;
    logic [4:0]             n_top;
    logic                   last_left;
    logic                   last_top;
    logic                   issue;
    logic [4:0]             issue_idx;
    logic [4:0]             top_sum;
    logic                   top_avail;
    logic [3:0]             left_x;
    logic [3:0]             left_y;
    logic [3:0]             up_y;
    logic [FW-1:0]          fra_adr;

    logic [1:0]             src;
    logic                   ena_row, ena_col, ena_fra;
    logic [7:0]             adr_row, adr_col;
    logic [FW-1:0]          adr_fra;
    logic [DW-1:0]          dat;

    logic                   unused_low_bits;
    assign unused_low_bits = ^{bus.blk_x_i[1:0], bus.blk_y_i[1:0]};

    assign n_words   = 5'd1 << size_q;
    assign n_top     = {n_words[3:0], 1'b0};
    assign last_left = (cnt == n_words - 5'd1);
    assign last_top  = (cnt == n_top - 5'd1);
    assign issue     = (state == LEFT) || (state == TOP);
    assign issue_idx = (state == TOP) ? n_words + cnt : cnt;

    // Field arithmetic wraps at 16 on purpose; top-right overflow is caught via top_sum[4].
    assign left_x    = bx_q - 4'd1;
    assign left_y    = by_q + cnt[3:0];
    assign up_y      = by_q - 4'd1;
    assign top_sum   = {1'b0, bx_q} + cnt;
    assign top_avail = (cnt < n_words) ? at_q : atr_q;
    assign fra_adr   = {lcu_q, 4'b0000} + {{(FW-4){1'b0}}, bx_q} + {{(FW-5){1'b0}}, cnt};

    always_comb begin
        src     = SRC_PAD;
        ena_row = 1'b0;
        ena_col = 1'b0;
        ena_fra = 1'b0;
        adr_row = '0;
        adr_col = '0;
        adr_fra = '0;
        if (state == LEFT) begin
            if (al_q) begin
                src     = SRC_COL;
                ena_col = 1'b1;
                adr_col = {left_x, left_y};
            end
        end else if (state == TOP) begin
            if (by_q == 4'd0) begin
                if (top_avail) begin
                    src     = SRC_FRA;
                    ena_fra = 1'b1;
                    adr_fra = fra_adr;
                end
            end else if (top_avail && !top_sum[4]) begin
                src     = SRC_ROW;
                ena_row = 1'b1;
                adr_row = {up_y, top_sum[3:0]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            size_q <= '0;
            bx_q   <= '0;
            by_q   <= '0;
            lcu_q  <= '0;
            al_q   <= 1'b0;
            at_q   <= 1'b0;
            atr_q  <= 1'b0;
            val_q  <= 1'b0;
            idx_q  <= '0;
            tag_q  <= SRC_PAD;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        state  <= LEFT;
                        cnt    <= '0;
                        size_q <= bus.size_i;
                        bx_q   <= bus.blk_x_i[5:2];
                        by_q   <= bus.blk_y_i[5:2];
                        lcu_q  <= bus.lcu_x_i;
                        al_q   <= bus.avail_left_i;
                        at_q   <= bus.avail_top_i;
                        atr_q  <= bus.avail_tr_i;
                    end
                end
                LEFT: begin
                    if (last_left) begin
                        state <= TOP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                TOP: begin
                    if (last_top) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Return stage: the tag remembers which SRAM (or padding) owns next cycle's data.
            val_q  <= issue;
            idx_q  <= issue ? issue_idx : 5'd0;
            tag_q  <= issue ? src : SRC_PAD;
            done_q <= (state == TOP) && last_top;
        end
    end

    always_comb begin
        dat = '0;
        if (val_q) begin
            case (tag_q)
                SRC_COL: dat = bus.rd_dat_col_i;
                SRC_ROW: dat = bus.rd_dat_row_i;
                SRC_FRA: dat = bus.rd_dat_fra_i;
                default: dat = PAD_WORD;
            endcase
        end
    end

    assign bus.rd_ena_row_o = ena_row;
    assign bus.rd_adr_row_o = adr_row;
    assign bus.rd_ena_col_o = ena_col;
    assign bus.rd_adr_col_o = adr_col;
    assign bus.rd_ena_fra_o = ena_fra;
    assign bus.rd_adr_fra_o = adr_fra;
    assign bus.busy_o       = (state != IDLE);
    assign bus.ref_val_o    = val_q;
    assign bus.ref_idx_o    = idx_q;
    assign bus.ref_dat_o    = dat;
    assign bus.done_o       = done_q;
endmodule

// File: tb/tb_intra_ref_fetch.sv
// tb/tb_intra_ref_fetch.sv - randomized and directed bench for intra_ref_fetch
module tb_intra_ref_fetch;
    localparam int PW  = 8;
    localparam int PXW = 8;
    localparam int FW  = PXW + 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    intra_ref_fetch_if #(.PIXEL_WIDTH(PW), .PIC_X_WIDTH(PXW)) bus ();
    intra_ref_fetch #(.PIXEL_WIDTH(PW), .PIC_X_WIDTH(PXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;
    int obs[$];

    // Source codes: 0 pad, 1 col, 2 row, 3 frame
    function automatic logic [31:0] mem_word(input int s, input int a);
        return {8'(s), 8'(a), 8'(a >> 8), 8'(a ^ 8'h3c)};
    endfunction

    always @(posedge clk) begin
        bus.rd_dat_row_i <= bus.rd_ena_row_o ? mem_word(2, int'(bus.rd_adr_row_o)) : 32'hdeadbeef;
        bus.rd_dat_col_i <= bus.rd_ena_col_o ? mem_word(1, int'(bus.rd_adr_col_o)) : 32'hdeadbeef;
        bus.rd_dat_fra_i <= bus.rd_ena_fra_o ? mem_word(3, int'(bus.rd_adr_fra_o)) : 32'hdeadbeef;
    end

    function automatic void model_word(input int size, input int bxp, input int byp, input int lcu,
                                       input bit al, input bit at, input bit atr, input int i,
                                       output int s, output int adr);
        int n, bx, by, k;
        bit av;
        n = 1 << size; bx = bxp / 4; by = byp / 4;
        s = 0; adr = 0;
        if (i < n) begin
            s   = al ? 1 : 0;
            adr = ((bx + 15) % 16) * 16 + (by + i) % 16;
        end else begin
            k  = i - n;
            av = (k < n) ? at : atr;
            if (byp == 0) begin
                s   = av ? 3 : 0;
                adr = (lcu * 16 + bx + k) % (1 << FW);
            end else begin
                s   = (av && (bx + k < 16)) ? 2 : 0;
                adr = ((by + 15) % 16) * 16 + (bx + k) % 16;
            end
        end
    endfunction

    task automatic scramble_inputs();
        bus.size_i       = 2'($urandom);
        bus.blk_x_i      = 6'($urandom);
        bus.blk_y_i      = 6'($urandom);
        bus.lcu_x_i      = PXW'($urandom);
        bus.avail_left_i = 1'($urandom);
        bus.avail_top_i  = 1'($urandom);
        bus.avail_tr_i   = 1'($urandom);
    endtask

    // Called at a negedge; start is seen by the following posedge (cycle 0).
    task automatic run_fetch(input string name, input int size, input int bxp, input int byp,
                             input int lcu, input bit al, input bit at, input bit atr,
                             input bit restart);
        int total, s, adr, oadr;
        logic [2:0] ena_v, exp_v;
        logic [31:0] exp_dat;
        total = 3 * (1 << size);
        obs.delete();
        bus.start_i = 1'b1;
        bus.size_i = 2'(size); bus.blk_x_i = 6'(bxp); bus.blk_y_i = 6'(byp);
        bus.lcu_x_i = PXW'(lcu);
        bus.avail_left_i = al; bus.avail_top_i = at; bus.avail_tr_i = atr;
        for (int c = 1; c <= total + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start_i = 1'b0;
                scramble_inputs();
            end
            ena_v = {bus.rd_ena_row_o, bus.rd_ena_col_o, bus.rd_ena_fra_o};
            oadr  = bus.rd_ena_row_o ? int'(bus.rd_adr_row_o) :
                    bus.rd_ena_col_o ? int'(bus.rd_adr_col_o) : int'(bus.rd_adr_fra_o);
            if (ena_v != 3'b000) obs.push_back(oadr);
            exp_v = 3'b000; adr = 0;
            if (c <= total) begin
                model_word(size, bxp, byp, lcu, al, at, atr, c - 1, s, adr);
                exp_v = (s == 2) ? 3'b100 : (s == 1) ? 3'b010 : (s == 3) ? 3'b001 : 3'b000;
            end
            checks++;
            if (ena_v !== exp_v) $display("FAIL %s rd_ena cycle %0d: got %b want %b", name, c, ena_v, exp_v);
            else passes++;
            if (exp_v != 3'b000) begin
                checks++;
                if (oadr !== adr) $display("FAIL %s rd_adr cycle %0d: got %0d want %0d", name, c, oadr, adr);
                else passes++;
            end
            checks++;
            if (c >= 2 && c <= total + 1) begin
                model_word(size, bxp, byp, lcu, al, at, atr, c - 2, s, adr);
                exp_dat = (s == 0) ? 32'h80808080 : mem_word(s, adr);
                if ({bus.ref_val_o, bus.ref_idx_o, bus.ref_dat_o} !== {1'b1, 5'(c - 2), exp_dat})
                    $display("FAIL %s ref cycle %0d: got val=%b idx=%0d dat=%h want val=1 idx=%0d dat=%h",
                             name, c, bus.ref_val_o, bus.ref_idx_o, bus.ref_dat_o, c - 2, exp_dat);
                else passes++;
            end else begin
                if (bus.ref_val_o !== 1'b0) $display("FAIL %s ref_val cycle %0d: got %b want 0", name, c, bus.ref_val_o);
                else passes++;
            end
            checks++;
            if (bus.done_o !== (c == total + 1)) $display("FAIL %s done cycle %0d: got %b want %b", name, c, bus.done_o, c == total + 1);
            else passes++;
            checks++;
            if (bus.busy_o !== (c <= total + 1)) $display("FAIL %s busy cycle %0d: got %b want %b", name, c, bus.busy_o, c <= total + 1);
            else passes++;
            if (c == 2) bus.start_i = restart;
            if (c == 3) bus.start_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0;
        scramble_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy_o, bus.ref_val_o, bus.done_o, bus.ref_idx_o, bus.ref_dat_o,
             bus.rd_ena_row_o, bus.rd_ena_col_o, bus.rd_ena_fra_o} !== '0)
            $display("FAIL reset_state: got busy=%b val=%b done=%b idx=%0d dat=%h ena=%b%b%b want all 0",
                     bus.busy_o, bus.ref_val_o, bus.done_o, bus.ref_idx_o, bus.ref_dat_o,
                     bus.rd_ena_row_o, bus.rd_ena_col_o, bus.rd_ena_fra_o);
        else passes++;
    endtask

    task automatic test_4x4();
        run_fetch("blk4x4", 0, 8, 8, 5, 1, 1, 1, 0);
        checks++;
        if (obs.size() != 3 || obs[0] != 'h12 || obs[1] != 'h12 || obs[2] != 'h13)
            $display("FAIL blk4x4_addr: got %p want '{18,18,19}", obs);
        else passes++;
    endtask

    task automatic test_frame_crossing();
        run_fetch("frame_cross", 1, 56, 0, 3, 1, 1, 1, 0);
        checks++;
        if (obs.size() != 6 || obs[0] != 'hd0 || obs[1] != 'hd1 || obs[2] != 62 ||
            obs[3] != 63 || obs[4] != 64 || obs[5] != 65)
            $display("FAIL frame_cross_addr: got %p want '{208,209,62,63,64,65}", obs);
        else passes++;
    endtask

    task automatic test_padding();
        run_fetch("pad16", 2, 16, 16, 0, 0, 1, 0, 0);
        checks++;
        if (obs.size() != 4) $display("FAIL pad16_reads: got %0d want 4", obs.size());
        else passes++;
    endtask

    task automatic test_row_overflow();
        run_fetch("row_ovf", 3, 32, 32, 0, 1, 1, 1, 0);
        checks++;
        if (obs.size() != 16) $display("FAIL row_ovf_reads: got %0d want 16", obs.size());
        else passes++;
    endtask

    task automatic test_start_ignored();
        run_fetch("restart", 1, 20, 12, 7, 1, 1, 1, 1);
    endtask

    task automatic test_reset_mid_fetch();
        bus.start_i = 1'b1;
        bus.size_i = 2'd1; bus.blk_x_i = 6'd24; bus.blk_y_i = 6'd16; bus.lcu_x_i = 8'd9;
        bus.avail_left_i = 1'b1; bus.avail_top_i = 1'b1; bus.avail_tr_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy_o, bus.ref_val_o, bus.done_o, bus.ref_idx_o, bus.ref_dat_o,
             bus.rd_ena_row_o, bus.rd_ena_col_o, bus.rd_ena_fra_o} !== '0)
            $display("FAIL mid_reset_outputs: got busy=%b val=%b idx=%0d dat=%h want all 0",
                     bus.busy_o, bus.ref_val_o, bus.ref_idx_o, bus.ref_dat_o);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_fetch("after_reset", 1, 24, 16, 9, 1, 1, 1, 0);
    endtask

    task automatic test_back_to_back();
        int byp;
        for (int t = 0; t < 10; t++) begin
            byp = ($urandom_range(0, 2) == 0) ? 0 : 4 * $urandom_range(0, 15);
            run_fetch("random", $urandom_range(0, 3), 4 * $urandom_range(0, 15), byp,
                      $urandom_range(0, 255), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_4x4();
        test_frame_crossing();
        test_padding();
        test_row_overflow();
        test_start_ignored();
        test_reset_mid_fetch();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
